ifclocks_gen: RTL

Parametrised clock-enable generator that sits behind the PLL wrapper in the clocking domain. It qualifies the PLL `locked` indication and derives NCH independent fractional-rate clock-enable strobes from one PLL output clock, each with a matching square-wave output. Downstream logic runs on the single fast clock and uses these strobes, so it needs no extra PLL outputs and no clock-domain crossings. It replaces fixed per-frequency PLL outputs with run-time programmable rates, lock supervision and phase alignment.

---
 rtl/ifclocks_gen_if.sv | 26 ++
 rtl/ifclocks_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ifclocks_gen_if.sv
// Control/status bundle between the clocking-domain supervisor and ifclocks_gen.
// The slave modport is the generator side; the master modport is its controller.
interface ifclocks_gen_if #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned ACC_W = 24
);
  logic                 pll_locked;
  logic [NCH*ACC_W-1:0] inc;
  logic                 inc_load;
  logic                 phase_sync;
  logic                 lost_clr;
  logic [NCH-1:0]       ce;
  logic [NCH-1:0]       sq;
  logic                 ready;
  logic                 lock_lost;

  modport master (
    output pll_locked, inc, inc_load, phase_sync, lost_clr,
    input  ce, sq, ready, lock_lost
  );

  modport slave (
    input  pll_locked, inc, inc_load, phase_sync, lost_clr,
    output ce, sq, ready, lock_lost
  );
endinterface

// File: rtl/ifclocks_gen.sv
// Lock-qualified, run-time programmable fractional clock-enable generator:
// NCH phase accumulators produce ce strobes and half-rate square waves.
module ifclocks_gen #(
  parameter int unsigned NCH         = 3,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ifclocks_gen_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [NCH*ACC_W-1:0] INC_RST = {NCH{{1'b1, {(ACC_W-1){1'b0}}}}};

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     lock_cnt_q;
  logic                 ready_q;
  logic                 lost_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 lock_s;

  logic [NCH*ACC_W-1:0] acc_q, acc_d;
  logic [NCH*ACC_W-1:0] inc_sh_q;
  logic [NCH-1:0]       ce_q, ce_d;
  logic [NCH-1:0]       sq_q, sq_d;
  logic [ACC_W:0]       sum;
  logic                 run_keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // lost_clr is applied first so that a loss detected in RUN on the same edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      ready_q    <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      if (bus.lost_clr) lost_q <= 1'b0;
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            lock_cnt_q <= '0;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
          end else if (lock_cnt_q == CNT_LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            ready_q <= 1'b0;
            lost_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Accumulate only on edges that stay in RUN; the leaving edge clears like phase_sync.
  assign run_keep = (state_q == RUN) && lock_s;

  always_comb begin
    acc_d = '0;
    ce_d  = '0;
    sq_d  = '0;
    sum   = '0;
    if (run_keep && !bus.phase_sync) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        sum = {1'b0, acc_q[i*ACC_W +: ACC_W]} + {1'b0, inc_sh_q[i*ACC_W +: ACC_W]};
        acc_d[i*ACC_W +: ACC_W] = sum[ACC_W-1:0];
        ce_d[i] = sum[ACC_W];
        sq_d[i] = sq_q[i] ^ sum[ACC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      ce_q     <= '0;
      sq_q     <= '0;
      inc_sh_q <= INC_RST;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
      sq_q  <= sq_d;
      if (bus.inc_load) inc_sh_q <= bus.inc;
    end
  end

  assign bus.ce        = ce_q;
  assign bus.sq        = sq_q;
  assign bus.ready     = ready_q;
  assign bus.lock_lost = lost_q;

endmodule
